// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS_32 data-memory stage: opcodes, FSM
// states, access sizes and small decode helpers.
package mips_pkg;

  localparam logic [5:0] OP_LB = 6'b100000;
  localparam logic [5:0] OP_LH = 6'b100001;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SB = 6'b101000;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SW = 6'b101011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_FINISH
  } state_t;

  typedef enum logic [1:0] {
    BYTE,
    HALF,
    WORD
  } size_t;

  function automatic logic is_mem_op(input logic [5:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_SB, OP_SH, OP_SW};
  endfunction

  // Stores are 101xxx, loads are 100xxx.
  function automatic logic is_store_op(input logic [5:0] op);
    return op[3];
  endfunction

  function automatic size_t op_size(input logic [5:0] op);
    case (op[1:0])
      2'b00:   return BYTE;
      2'b01:   return HALF;
      default: return WORD;
    endcase
  endfunction

  function automatic logic misaligned(input size_t sz, input logic [1:0] off);
    case (sz)
      HALF:    return off[0];
      WORD:    return |off;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_lane_align.sv
// Big-endian lane steering: byte enables and replicated store data for the
// memory port, and selection plus sign-extension of load data.
module mips_lane_align
  import mips_pkg::*;
(
  input  size_t       size_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] rd_data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ld_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Offset 0 addresses bits 31:24; halfwords use address bit 1 only.
  always_comb begin
    be_o      = '0;
    wdata_o   = '0;
    ld_data_o = '0;
    byte_sel  = '0;
    half_sel  = '0;
    case (size_i)
      BYTE: begin
        be_o    = 4'b1000 >> offset_i;
        wdata_o = {4{st_data_i[7:0]}};
        case (offset_i)
          2'd0:    byte_sel = rd_data_i[31:24];
          2'd1:    byte_sel = rd_data_i[23:16];
          2'd2:    byte_sel = rd_data_i[15:8];
          default: byte_sel = rd_data_i[7:0];
        endcase
        ld_data_o = {{24{byte_sel[7]}}, byte_sel};
      end
      HALF: begin
        be_o      = offset_i[1] ? 4'b0011 : 4'b1100;
        wdata_o   = {2{st_data_i[15:0]}};
        half_sel  = offset_i[1] ? rd_data_i[15:0] : rd_data_i[31:16];
        ld_data_o = {{16{half_sel[15]}}, half_sel};
      end
      default: begin
        be_o      = '1;
        wdata_o   = st_data_i;
        ld_data_o = rd_data_i;
      end
    endcase
  end

endmodule

// File: rtl/mips_mem_stage.sv
// MIPS_32 data-memory access stage. Drives a request/acknowledge word port
// for lb/lh/lw/sb/sh/sw with an ack timeout; other opcodes complete in one
// pass through FINISH. Optional macro MEM_ALIGN_CHECK_EN turns misaligned
// halfword/word accesses into immediate errors without a memory request.
module mips_mem_stage
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [5:0]        opcode,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic [31:0]       rt_reg,
  output logic              busy,
  output logic              done,
  output logic [31:0]       load_data,
  output logic              mem_error,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [31:0]       load_q;
  logic              accept, ld_en, misalign, in_access;

  size_t             size_q;
  logic [1:0]        off_q;
  logic              store_q;
  logic [ADDR_W-3:0] addr_q;
  logic [31:0]       st_q;

  logic [3:0]        al_be;
  logic [31:0]       al_wdata, al_ld;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = misaligned(op_size(opcode), alu_result[1:0]);
`else
  assign misalign = 1'b0;
`endif

  mips_lane_align u_align (
    .size_i    (size_q),
    .offset_i  (off_q),
    .st_data_i (st_q),
    .rd_data_i (mem_rdata),
    .be_o      (al_be),
    .wdata_o   (al_wdata),
    .ld_data_o (al_ld)
  );

  // Next-state, timeout counter and error flag.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    accept  = 1'b0;
    ld_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (is_mem_op(opcode) && !misalign) begin
            accept  = 1'b1;
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = S_ACCESS;
          end else begin
            err_d   = misalign && is_mem_op(opcode);
            state_d = S_FINISH;
          end
        end
      end
      S_ACCESS: begin
        // Ack takes priority over a timeout in the same cycle.
        if (mem_ack) begin
          ld_en   = !store_q;
          state_d = S_FINISH;
        end else if (cnt_q == CNT_MAX) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM state, counter, error flag and held load result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (ld_en) load_q <= al_ld;
    end
  end

  // Request attributes captured when a memory access is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      size_q  <= BYTE;
      off_q   <= '0;
      store_q <= 1'b0;
      addr_q  <= '0;
      st_q    <= '0;
    end else if (accept) begin
      size_q  <= op_size(opcode);
      off_q   <= alu_result[1:0];
      store_q <= is_store_op(opcode);
      addr_q  <= alu_result[ADDR_W-1:2];
      st_q    <= rt_reg;
    end
  end

  assign in_access = (state_q == S_ACCESS);
  assign busy      = in_access;
  assign mem_req   = in_access;
  assign mem_we    = in_access & store_q;
  assign mem_addr  = in_access ? addr_q : '0;
  assign mem_be    = in_access ? al_be : '0;
  assign mem_wdata = in_access ? al_wdata : '0;
  assign done      = (state_q == S_FINISH);
  assign mem_error = done & err_q;
  assign load_data = load_q;

endmodule

// File: tb/tb_mips_mem_stage.sv
// Directed bench for mips_mem_stage: a table of single accesses plus
// hand-written timeout, pass-through, alignment and reset sequences.
module tb_mips_mem_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  opcode;
  logic [31:0] alu_result;
  logic [31:0] rt_reg;
  logic        busy, done, mem_error, mem_req, mem_we;
  logic [31:0] load_data, mem_wdata, mem_rdata;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic        mem_ack;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  mips_mem_stage #(.TIMEOUT(16), .ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .opcode     (opcode),
    .alu_result (alu_result),
    .rt_reg     (rt_reg),
    .busy       (busy),
    .done       (done),
    .load_data  (load_data),
    .mem_error  (mem_error),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] rt;
    logic [31:0] rdata;
    int unsigned dly;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_we;
    logic [31:0] e_load;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int unsigned k, input vec_t v);
    @(negedge clk);
    start = 1'b1; opcode = v.op; alu_result = v.addr; rt_reg = v.rt;
    @(negedge clk);
    start = 1'b0; opcode = '0; alu_result = '0; rt_reg = '0;
    chk($sformatf("v%0d_req", k),   32'(mem_req), 32'd1);
    chk($sformatf("v%0d_busy", k),  32'(busy), 32'd1);
    chk($sformatf("v%0d_we", k),    32'(mem_we), 32'(v.e_we));
    chk($sformatf("v%0d_addr", k),  32'(mem_addr), v.e_addr);
    chk($sformatf("v%0d_be", k),    32'(mem_be), 32'(v.e_be));
    chk($sformatf("v%0d_wdata", k), mem_wdata, v.e_wdata);
    for (int unsigned c = 0; c < v.dly; c++) begin
      @(negedge clk);
      chk($sformatf("v%0d_req_hold", k),  32'(mem_req), 32'd1);
      chk($sformatf("v%0d_addr_hold", k), 32'(mem_addr), v.e_addr);
    end
    mem_ack = 1'b1; mem_rdata = v.rdata;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = '0;
    chk($sformatf("v%0d_done", k),  32'(done), 32'd1);
    chk($sformatf("v%0d_err", k),   32'(mem_error), 32'd0);
    chk($sformatf("v%0d_req_off", k), 32'(mem_req), 32'd0);
    chk($sformatf("v%0d_load", k),  load_data, v.e_load);
    @(negedge clk);
    chk($sformatf("v%0d_done_pulse", k), 32'(done), 32'd0);
  endtask

  initial begin
    int unsigned n, g, early;
    logic [31:0] exp_load;

    //            op     addr          rt            rdata         dly addr          be       wdata         we    load
    vecs[0]  = '{OP_SW, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,        2, 32'h4,        4'b1111, 32'hDEAD_BEEF, 1'b1, 32'h0};
    vecs[1]  = '{OP_LB, 32'h0000_0013, 32'h0000_00AB, 32'h1122_3380, 1, 32'h4,        4'b0001, 32'hABAB_ABAB, 1'b0, 32'hFFFF_FF80};
    vecs[2]  = '{OP_LB, 32'h0000_0010, 32'h0000_00AB, 32'h1122_3380, 0, 32'h4,        4'b1000, 32'hABAB_ABAB, 1'b0, 32'h0000_0011};
    vecs[3]  = '{OP_SH, 32'h0000_0002, 32'h0000_A5C3, 32'h0,        1, 32'h0,        4'b0011, 32'hA5C3_A5C3, 1'b1, 32'h0000_0011};
    vecs[4]  = '{OP_LH, 32'h0000_0002, 32'h0,        32'h0000_8001, 3, 32'h0,        4'b0011, 32'h0,        1'b0, 32'hFFFF_8001};
    vecs[5]  = '{OP_LW, 32'h0000_0100, 32'h0,        32'hCAFE_F00D, 0, 32'h40,       4'b1111, 32'h0,        1'b0, 32'hCAFE_F00D};
    vecs[6]  = '{OP_LH, 32'h0000_0004, 32'h1234_5678, 32'h7FFF_0000, 1, 32'h1,        4'b1100, 32'h5678_5678, 1'b0, 32'h0000_7FFF};
    vecs[7]  = '{OP_LB, 32'h0000_0005, 32'h0000_009C, 32'h00FF_0000, 2, 32'h1,        4'b0100, 32'h9C9C_9C9C, 1'b0, 32'hFFFF_FFFF};
    vecs[8]  = '{OP_SB, 32'h0000_0006, 32'h1234_5677, 32'h0,        0, 32'h1,        4'b0010, 32'h7777_7777, 1'b1, 32'hFFFF_FFFF};
    vecs[9]  = '{OP_LB, 32'h0000_0007, 32'h0,        32'h0000_007F, 0, 32'h1,        4'b0001, 32'h0,        1'b0, 32'h0000_007F};
    vecs[10] = '{OP_LW, 32'h0000_0030, 32'h0,        32'h8000_0001, 15, 32'hC,       4'b1111, 32'h0,        1'b0, 32'h8000_0001};
    vecs[11] = '{OP_SW, 32'hFFFF_FFFC, 32'h0123_4567, 32'h0,        1, 32'h3FFF_FFFF, 4'b1111, 32'h0123_4567, 1'b1, 32'h8000_0001};

    reset = 1'b1; start = 1'b0; opcode = '0; alu_result = '0; rt_reg = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_err", 32'(mem_error), 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    chk("rst_load", load_data, 32'd0);
    reset = 1'b0;

    for (int unsigned k = 0; k < 12; k++) run_vec(k, vecs[k]);
    exp_load = 32'h8000_0001;

    // Timeout with no ack; a start mid-access must be ignored.
    @(negedge clk);
    start = 1'b1; opcode = OP_LW; alu_result = 32'h20;
    @(negedge clk);
    start = 1'b0;
    n = 0; g = 0; early = 0;
    while (mem_req && g < 40) begin
      n++;
      if (done) early++;
      if (n == 5) begin start = 1'b1; opcode = OP_SW; end
      else begin start = 1'b0; opcode = '0; end
      @(negedge clk);
      g++;
    end
    start = 1'b0; opcode = '0;
    chk("to_req_cycles", n, 32'd16);
    chk("to_early_done", early, 32'd0);
    chk("to_done", 32'(done), 32'd1);
    chk("to_err", 32'(mem_error), 32'd1);
    chk("to_load_kept", load_data, exp_load);
    // Start presented during FINISH is dropped.
    start = 1'b1; opcode = OP_LW; alu_result = 32'h40;
    @(negedge clk);
    start = 1'b0; opcode = '0;
    chk("fin_start_req", 32'(mem_req), 32'd0);
    chk("fin_start_busy", 32'(busy), 32'd0);
    chk("fin_start_done", 32'(done), 32'd0);

    // Non-memory opcode passes straight to FINISH.
    @(negedge clk);
    start = 1'b1; opcode = 6'b000000; alu_result = 32'h10;
    @(negedge clk);
    start = 1'b0;
    chk("add_done", 32'(done), 32'd1);
    chk("add_err", 32'(mem_error), 32'd0);
    chk("add_req", 32'(mem_req), 32'd0);
    chk("add_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("add_done_pulse", 32'(done), 32'd0);

    // Misaligned word load.
    @(negedge clk);
    start = 1'b1; opcode = OP_LW; alu_result = 32'h0000_0101;
    @(negedge clk);
    start = 1'b0; opcode = '0;
`ifdef MEM_ALIGN_CHECK_EN
    chk("mis_done", 32'(done), 32'd1);
    chk("mis_err", 32'(mem_error), 32'd1);
    chk("mis_req", 32'(mem_req), 32'd0);
    chk("mis_load_kept", load_data, exp_load);
    @(negedge clk);
    chk("mis_req_after", 32'(mem_req), 32'd0);
`else
    chk("mis_req", 32'(mem_req), 32'd1);
    chk("mis_addr", 32'(mem_addr), 32'h40);
    chk("mis_be", 32'(mem_be), 32'hF);
    mem_ack = 1'b1; mem_rdata = 32'h0A0B_0C0D;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = '0;
    chk("mis_done", 32'(done), 32'd1);
    chk("mis_err", 32'(mem_error), 32'd0);
    chk("mis_load", load_data, 32'h0A0B_0C0D);
    @(negedge clk);
`endif

    // Reset during ACCESS, then a late ack.
    @(negedge clk);
    start = 1'b1; opcode = OP_LW; alu_result = 32'h80;
    @(negedge clk);
    start = 1'b0; opcode = '0;
    chk("rma_req", 32'(mem_req), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rma_req_drop", 32'(mem_req), 32'd0);
    chk("rma_done", 32'(done), 32'd0);
    chk("rma_busy", 32'(busy), 32'd0);
    chk("rma_load", load_data, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = '0;
    chk("late_ack_done", 32'(done), 32'd0);
    chk("late_ack_load", load_data, 32'd0);
    @(negedge clk);
    chk("late_ack_done2", 32'(done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_mem_stage.md
Name: mips_mem_stage

Overview:
Data-memory access stage directly downstream of the ALU in the MIPS_32 datapath.
- Consumes the ALU's effective address (rs + sign-extended imm) for lb/lh/lw/sb/sh/sw.
- Drives a word-wide, request/acknowledge data-memory port: byte enables, lane steering, load sign-extension, ack timeout.
- Non-memory opcodes pass through with a one-cycle done so the controller sees uniform timing.

Parameters:
TIMEOUT, 16, max cycles mem_req stays high without mem_ack before the access is aborted (≥1)
ADDR_W, 32, effective-address width; mem_addr is ADDR_W-2 bits

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse; opcode/alu_result/rt_reg valid this cycle
opcode  in  6  instruction opcode
alu_result  in  ADDR_W  effective byte address from ALU
rt_reg  in  32  store data
busy  out  1  high from accepted start until done
done  out  1  one-cycle completion pulse
load_data  out  32  extended load result, held until next load completes
mem_error  out  1  valid with done; timeout (or misalign, see feature)
mem_req  out  1  memory request, held until ack or timeout
mem_we  out  1  1 = write
mem_addr  out  ADDR_W-2  word address = alu_result[ADDR_W-1:2]
mem_be  out  4  byte enables, be[3] = bits 31:24
mem_wdata  out  32  lane-steered store data
mem_rdata  in  32  read data, valid with mem_ack
mem_ack  in  1  one-cycle acknowledge

Behaviour:
- Clock/reset: one clock, clk; reset synchronous active-high.
- Reset values: all outputs 0, FSM in IDLE, timeout counter 0.
- FSM states IDLE, ACCESS, FINISH.
- IDLE:
  - start with a memory opcode: latch op, address, store data; go to ACCESS. busy=1 the next cycle.
  - start with any other opcode: go to FINISH, no mem_req.
  - start while not in IDLE is ignored.
- ACCESS:
  - mem_req=1; mem_we/mem_addr/mem_be/mem_wdata stable for the whole state.
  - Counter increments each cycle without ack.
  - On mem_ack: capture and extend mem_rdata for loads, then go to FINISH.
  - If the counter reaches TIMEOUT-1 with no ack: drop mem_req, set the error flag, go to FINISH.
  - An ack arriving in the same cycle as the timeout wins; no error.
- FINISH: done=1 and mem_error=flag for one cycle; busy=0; return to IDLE. A start arriving in this cycle is ignored.
- Latency: start at cycle T → mem_req from T+1; ack at cycle A → done at A+1. Minimum 3 cycles start-to-done.
- Big-endian lanes. Byte offset o = alu_result[1:0]; offset 0 maps to bits 31:24.
- Byte ops (lb 100000, sb 101000):
  - be = 1000 >> o.
  - Store replicates rt[7:0] into all four lanes.
  - Load sign-extends the selected byte.
- Halfword ops (lh 100001, sh 101001):
  - Use alu_result[1] only: 0 → be=1100, 1 → be=0011.
  - Store replicates rt[15:0] into both halves.
  - Load sign-extends the selected halfword.
- Word ops (lw 100011, sw 101011): be=1111, data unchanged.
- Stores leave load_data unchanged.
- Reset mid-access: mem_req drops the next cycle, no done, return to IDLE. A late ack is ignored.

Optional Feature:
MEM_ALIGN_CHECK_EN
- Defined: misaligned lh/sh (bit0≠0) or lw/sw (bits[1:0]≠0) skip ACCESS and go to FINISH with mem_error=1. No mem_req is issued.
- Undefined: misaligned low address bits are ignored; halfword uses alignment bit 1, word uses word alignment; never an error.

Decomposition:
- Shared package mips_pkg holds:
  - opcode localparams OP_LB, OP_LH, OP_LW, OP_SB, OP_SH, OP_SW;
  - FSM state typedef;
  - size enum BYTE/HALF/WORD.
- One sub-module, mips_lane_align: combinational be/wdata steering and load extraction/sign-extension from size, offset and data.

Test Plan:
- sw: alu_result=0x0000_0010, rt=0xDEAD_BEEF, ack after 2 cycles → mem_addr=0x4, be=1111, wdata=0xDEADBEEF, done at ack+1, mem_error=0.
- lb: address 0x13, mem_rdata=0x1122_3380 → be=0001, load_data=0xFFFF_FF80; repeat with address 0x10 → load_data=0x0000_0011.
- sh at 0x2, rt=0x0000_A5C3 → be=0011, wdata=0xA5C3_A5C3; then lh at 0x2, rdata=0x0000_8001 → load_data=0xFFFF_8001.
- No ack with TIMEOUT=16 → mem_req high exactly 16 cycles, then done with mem_error=1; a start during busy is ignored.
- add opcode (000000) start → done next+1 cycle, mem_req never high. Reset asserted during ACCESS → mem_req=0 next cycle, no done.
- With MEM_ALIGN_CHECK_EN, lw at 0x...01 → done, mem_error=1, no mem_req. Without it → mem_addr word-aligned, be=1111.
